axis_pkt_arbiter: RTL and testbench
===================================

Name: axis_pkt_arbiter

Overview:
- Packet-level round-robin arbiter and mux that merges NUM_PORTS AXI-Stream FIFO outputs into one AXI-Stream master.
- Sits between the per-channel stream FIFOs (upstream) and the shared downstream consumer.
- Locks the grant for a whole packet (first beat through tlast), then rotates to the next requester.
- Output is a single registered pipeline stage; m_axis_tid reports the source port.

Parameters:
- NUM_PORTS, 4, number of slave stream inputs (>=1)
- DATA_WIDTH, 32, tdata width per port
- KEEP_WIDTH, 4, tkeep width per port
- ID_WIDTH, (NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1), width of m_axis_tid and the grant index

Ports:
- s_axis_aclk  in  1  single clock for all logic
- s_axis_aresetn  in  1  synchronous active-low reset
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port p at bits [p*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  port p at bits [p*KEEP_WIDTH +: KEEP_WIDTH]
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit high
- m_axis_tvalid  out  1  registered output valid
- m_axis_tdata  out  DATA_WIDTH  registered data
- m_axis_tkeep  out  KEEP_WIDTH  registered keep
- m_axis_tlast  out  1  registered last
- m_axis_tid  out  ID_WIDTH  source port of the current output beat
- m_axis_tready  in  1  downstream ready
- busy  out  1  high while in XFER state

Behaviour:
- One clock: s_axis_aclk. Reset is synchronous, active-low, on s_axis_aresetn.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tid=0
  - s_axis_tready=0, busy=0, state=IDLE
  - last_grant=NUM_PORTS-1, so port 0 has first priority after reset.
- Reset mid-packet aborts the packet. The partial packet is not completed, and the output beat held in the register is dropped.
- FSM states: IDLE, XFER.
- IDLE:
  - s_axis_tready all 0.
  - If any s_axis_tvalid is set, pick the first set port searching upward from (last_grant+1) modulo NUM_PORTS.
  - Register it as grant and go to XFER. Arbitration costs exactly 1 cycle.
  - If no port is valid, stay in IDLE.
- XFER:
  - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). All other ready bits are 0.
  - Accept condition: s_axis_tvalid[grant] && s_axis_tready[grant].
  - On accept, load the m_axis_t* registers from port grant, set m_axis_tid=grant and m_axis_tvalid=1.
  - Latency: an input beat appears on m_axis one cycle after it is accepted.
  - On accepting a beat with tlast=1, set last_grant=grant and go to IDLE.
  - Without an accept, if m_axis_tready=1 then m_axis_tvalid goes to 0.
- The output register drains independently of state. IDLE arbitration overlaps with draining the last beat.
- Throughput: 1 beat/cycle within a packet, with 1 idle input cycle between packets.
- Backpressure: while m_axis_tvalid && !m_axis_tready, all m_axis_t* stay stable and no input is accepted.
- The granted port dropping tvalid mid-packet keeps the grant (no timeout). Other ports wait.
- Single-beat packet (tlast on the first beat) gives an XFER of one cycle.
- Round-robin wrap: last_grant=NUM_PORTS-1 means the search starts at port 0.
- tkeep and tdata pass through unmodified. No width conversion.
- NUM_PORTS=1 degenerates to a registered pass-through with the same 1-cycle arbitration gap.

Optional Feature:
- Macro: AXIS_PKT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid port always wins in IDLE, and last_grant is ignored.
- Undefined (default): round-robin as specified above.
- Ports, latency and packet locking are identical in both modes.

Decomposition:
- Package axis_arb_pkg holds:
  - the state enum typedef (IDLE, XFER)
  - the ID_WIDTH computation as a function clog2_min1
- Sub-module axis_rr_select, combinational:
  - inputs: req[NUM_PORTS], last_grant
  - outputs: grant index and any_req
  - contains the macro-selected priority logic.
- The top level holds the FSM, the ready generation and the output register.

Test Plan:
- Reset then a single 4-beat packet on port 2, m_axis_tready=1:
  - s_axis_tready[2] rises 1 cycle after tvalid.
  - 4 output beats, each one cycle after acceptance, with tid=2 and tlast on beat 4.
  - busy deasserts after that.
- Ports 0,1,2,3 all continuously valid with 2-beat packets: output tid sequence is 0,1,2,3,0, with one gap cycle between packets. With the macro defined, tid stays 0 throughout.
- Backpressure: m_axis_tready=0 for 5 cycles mid-packet → m_axis_tdata/tkeep/tlast/tid stay stable, s_axis_tready[grant]=0, and no beat is lost or duplicated.
- Granted port 1 drops tvalid for 3 cycles mid-packet while port 3 is valid → port 3 gets no tready and no beat from port 3 interleaves; port 3 is granted after port 1's tlast.
- Assert s_axis_aresetn=0 for 1 cycle on beat 2 of a 6-beat packet from port 1:
  - all outputs reach their reset values next cycle.
  - with ports 0 and 1 valid afterwards, port 0 is granted first.
- NUM_PORTS=1 build, back-to-back 1-beat packets → each accepted, with one IDLE cycle between them.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet arbiter: FSM state encoding and
// the index-width helper that keeps single-port builds at a 1-bit id.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the arbiter's stream signals: NUM_PORTS packed slave streams in,
// one master stream out, plus the busy status flag.
interface axis_pkt_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int ID_WIDTH   = axis_arb_pkg::clog2_min1(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]            s_axis_tvalid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [NUM_PORTS-1:0]            s_axis_tlast;
    logic [NUM_PORTS-1:0]            s_axis_tready;
    logic                            m_axis_tvalid;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
    logic                            m_axis_tlast;
    logic [ID_WIDTH-1:0]             m_axis_tid;
    logic                            m_axis_tready;
    logic                            busy;

    // Arbiter side: consumes the slave streams, drives the merged stream.
    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        output m_axis_tid, busy
    );

    // Environment side: upstream FIFOs and downstream consumer.
    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        input  m_axis_tid, busy
    );
endinterface

// File: rtl/axis_rr_select.sv
// Combinational grant picker. Round-robin starting after last_grant by default;
// defining AXIS_PKT_ARB_FIXED_PRIO_EN switches to lowest-index-wins priority.
module axis_rr_select #(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = axis_arb_pkg::clog2_min1(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  last_grant,
    output logic [ID_WIDTH-1:0]  grant,
    output logic                 any_req
);

    assign any_req = |req;

`ifdef AXIS_PKT_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) grant = ID_WIDTH'(i);
        end
    end
`else
    logic [ID_WIDTH-1:0] rot_idx;

    // Walk the rotation backwards so the candidate closest after last_grant wins.
    always_comb begin
        grant   = '0;
        rot_idx = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            rot_idx = ID_WIDTH'((int'(last_grant) + i) % NUM_PORTS);
            if (req[rot_idx]) grant = rot_idx;
        end
    end
`endif

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-locked arbiter/mux merging NUM_PORTS AXI-Stream inputs into one
// registered output; m_axis_tid carries the source port of each beat.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int ID_WIDTH   = clog2_min1(NUM_PORTS)
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    axis_pkt_arbiter_if.master bus
);

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0]   sel_grant;
    logic                  any_req;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;
    logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic                  xfer_ready;
    logic                  accept;

    axis_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_select (
        .req        (bus.s_axis_tvalid),
        .last_grant (last_grant_q),
        .grant      (sel_grant),
        .any_req    (any_req)
    );

    // The granted port may push whenever the output register is empty or draining.
    assign xfer_ready = (state_q == XFER) && (!m_valid_q || bus.m_axis_tready);
    assign accept     = xfer_ready && bus.s_axis_tvalid[grant_q];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign bus.s_axis_tready[gi] = xfer_ready && (grant_q == ID_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_id_d       = m_id_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel_grant;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept && bus.s_axis_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output register drains on its own, regardless of arbitration state.
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.s_axis_tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            m_keep_d  = bus.s_axis_tkeep[int'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
            m_last_d  = bus.s_axis_tlast[grant_q];
            m_id_d    = grant_q;
        end else if (bus.m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_id_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_id_q       <= m_id_d;
        end
    end

    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tkeep  = m_keep_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.m_axis_tid    = m_id_q;
    assign bus.busy          = (state_q == XFER);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: a packet-level arbitration model fills
// the expected queue at load time; a monitor pops it on every output handshake.
module tb_axis_pkt_arbiter;
    import axis_arb_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int IW = clog2_min1(NP);

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        beat_t         b;
    } exp_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    axis_pkt_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) bus ();
    axis_pkt_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .bus            (bus)
    );

    axis_pkt_arbiter_if #(.NUM_PORTS(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(1)) bus1 ();
    axis_pkt_arbiter #(.NUM_PORTS(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(1)) dut1 (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .bus            (bus1)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t port_q [NP][$];
    exp_t  exp_q [$];
    int    model_lg = NP - 1;
    bit    sb_en = 1'b1;
    bit    gap_en = 1'b0;
    bit    bp_en = 1'b0;
    bit    strict_gap = 1'b0;
    int    force_gap_port = -1;
    int    force_gap_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit ports_empty();
        for (int p = 0; p < NP; p++) if (port_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Packets are loaded all at once, so the arbiter's valid set at every IDLE
    // decision is exactly the set of ports with packets left.
    task automatic load_phase(input logic [NP-1:0] mask, input int min_pk, input int max_pk,
                              input int min_len, input int max_len);
        int    lens [NP][$];
        beat_t pb [NP][$];
        beat_t b;
        exp_t  e;
        int    n, len, w;
        bit    more;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                n = $urandom_range(max_pk, min_pk);
                for (int k = 0; k < n; k++) begin
                    len = $urandom_range(max_len, min_len);
                    lens[p].push_back(len);
                    for (int j = 0; j < len; j++) begin
                        b.data = $urandom;
                        b.keep = KW'($urandom);
                        b.last = (j == len - 1);
                        pb[p].push_back(b);
                        port_q[p].push_back(b);
                    end
                end
            end
        end
        more = 1'b1;
        while (more) begin
            w = -1;
`ifdef AXIS_PKT_ARB_FIXED_PRIO_EN
            for (int p = 0; p < NP; p++) if (w < 0 && lens[p].size() != 0) w = p;
`else
            for (int k = 1; k <= NP; k++) if (w < 0 && lens[(model_lg + k) % NP].size() != 0) w = (model_lg + k) % NP;
`endif
            if (w < 0) begin
                more = 1'b0;
            end else begin
                for (int j = 0; j < lens[w][0]; j++) begin
                    e.id = IW'(w);
                    e.b  = pb[w].pop_front();
                    exp_q.push_back(e);
                end
                lens[w].delete(0);
                model_lg = w;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !ports_empty() || bus.busy || bus.m_axis_tvalid) && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d beats pending required=0", exp_q.size());
        end
        repeat (12) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        aresetn = 1'b0;
        for (int p = 0; p < NP; p++) port_q[p].delete();
        exp_q.delete();
        model_lg = NP - 1;
        repeat (2) @(posedge clk);
        #2;
        aresetn = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_tvalid"}, bus.m_axis_tvalid, 0);
        check({tag, "_m_tdata"}, bus.m_axis_tdata, 0);
        check({tag, "_m_tkeep"}, bus.m_axis_tkeep, 0);
        check({tag, "_m_tlast"}, bus.m_axis_tlast, 0);
        check({tag, "_m_tid"}, bus.m_axis_tid, 0);
        check({tag, "_s_tready"}, bus.s_axis_tready, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // Stimulus driver: presents queue heads, pops accepted beats, adds gaps/backpressure.
    initial begin : driver
        logic [NP-1:0]    acc, v;
        logic [NP*DW-1:0] d;
        logic [NP*KW-1:0] kp;
        logic [NP-1:0]    l;
        bit               mid [NP];
        int               gap_left [NP];
        int               bp_cnt;
        beat_t            tmp;
        bp_cnt = 0;
        for (int p = 0; p < NP; p++) begin mid[p] = 1'b0; gap_left[p] = 0; end
        bus.s_axis_tvalid = '0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
        bus.s_axis_tlast = '0; bus.m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            acc = aresetn ? (bus.s_axis_tvalid & bus.s_axis_tready) : '0;
            @(posedge clk); #1;
            v = '0; d = '0; kp = '0; l = '0;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && port_q[p].size() != 0) begin
                    tmp = port_q[p].pop_front();
                    mid[p] = !tmp.last;
                end
                if (port_q[p].size() == 0) begin
                    mid[p] = 1'b0;
                    gap_left[p] = 0;
                end else begin
                    if (mid[p] && gap_left[p] > 0) begin
                        gap_left[p]--;
                    end else if (mid[p] && p == force_gap_port && force_gap_len > 0) begin
                        gap_left[p] = force_gap_len - 1;
                        force_gap_len = 0;
                    end else if (!(mid[p] && gap_en && $urandom_range(3, 0) == 0)) begin
                        v[p] = 1'b1;
                    end
                    d[p*DW +: DW] = port_q[p][0].data;
                    kp[p*KW +: KW] = port_q[p][0].keep;
                    l[p] = port_q[p][0].last;
                end
            end
            bus.s_axis_tvalid = v; bus.s_axis_tdata = d; bus.s_axis_tkeep = kp; bus.s_axis_tlast = l;
            if (bp_cnt > 0) begin
                bp_cnt--;
                bus.m_axis_tready = 1'b0;
            end else if (bp_en && $urandom_range(7, 0) == 0) begin
                bp_cnt = 4;
                bus.m_axis_tready = 1'b0;
            end else begin
                bus.m_axis_tready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops plus protocol/timing checks, sampled mid-cycle.
    initial begin : monitor
        logic [NP-1:0] acc, prev_tv;
        logic [39:0]   snap, prev_snap;
        logic          prev_stall, prev_acc_v, prev_busy;
        beat_t         prev_acc_b, cur_b;
        int            prev_acc_port, cur_port, since_last;
        exp_t          e;
        prev_stall = 1'b0; prev_acc_v = 1'b0; prev_busy = 1'b0; prev_tv = '0;
        prev_snap = '0; prev_acc_b = '0; cur_b = '0; prev_acc_port = 0; since_last = -1;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_stall = 1'b0; prev_acc_v = 1'b0; prev_busy = 1'b0; prev_tv = '0; since_last = -1;
            end else begin
                acc  = bus.s_axis_tvalid & bus.s_axis_tready;
                snap = {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata, bus.m_axis_tid};
                check("ready_onehot0", $onehot0(bus.s_axis_tready), 1);
                if (prev_stall) check("stall_hold", snap, prev_snap);
                if (bus.m_axis_tvalid && !bus.m_axis_tready) check("stall_no_ready", bus.s_axis_tready, 0);
                if (prev_acc_v) begin
                    check("lat_beat", {bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata},
                          {1'b1, IW'(prev_acc_port), prev_acc_b});
                    if (prev_acc_b.last) check("busy_after_last", bus.busy, 0);
                end
                if (!prev_busy && prev_tv != '0) check("arb_1cycle", bus.busy, 1);
                cur_port = -1;
                for (int p = 0; p < NP; p++) begin
                    if (acc[p]) begin
                        cur_port = p;
                        cur_b = {bus.s_axis_tlast[p], bus.s_axis_tkeep[p*KW +: KW], bus.s_axis_tdata[p*DW +: DW]};
                    end
                end
                if (since_last >= 0) since_last++;
                if (since_last > 8) since_last = -1;
                if (cur_port >= 0) begin
                    if (strict_gap && since_last >= 0) check("pkt_gap", since_last, 2);
                    since_last = cur_b.last ? 0 : -1;
                end
                if (sb_en && bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected actual tid=%0d data=%0h required=no beat", bus.m_axis_tid, bus.m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_beat", {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, e);
                    end
                end
                prev_stall    = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_snap     = snap;
                prev_acc_v    = (cur_port >= 0);
                prev_acc_b    = cur_b;
                prev_acc_port = (cur_port >= 0) ? cur_port : 0;
                prev_busy     = bus.busy;
                prev_tv       = bus.s_axis_tvalid;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        int    n, nacc, since;
        logic  acc1, prev_acc1;
        logic [DW-1:0] prev_data;
        bus1.s_axis_tvalid = '0; bus1.s_axis_tdata = '0; bus1.s_axis_tkeep = '0;
        bus1.s_axis_tlast = '0; bus1.m_axis_tready = 1'b1;

        repeat (3) @(posedge clk);
        #2 aresetn = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #2;

        // Single 4-beat packet on port 2, no backpressure.
        load_phase(4'b0100, 1, 1, 4, 4);
        wait_drain();

        // All ports busy with 2-beat packets: strict rotation, one gap cycle each.
        do_reset();
        strict_gap = 1'b1;
        load_phase(4'b1111, 2, 2, 2, 2);
        wait_drain();
        strict_gap = 1'b0;

        // Backpressure only, then backpressure plus valid gaps.
        bp_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            load_phase(4'($urandom_range(15, 1)), 1, 2, 3, 6);
            wait_drain();
        end
        gap_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            load_phase(4'($urandom_range(15, 1)), 0, 3, 1, 6);
            wait_drain();
        end
        gap_en = 1'b0;
        bp_en = 1'b0;

        // Granted port 1 stalls 3 cycles mid-packet while port 3 waits.
        do_reset();
        force_gap_port = 1;
        force_gap_len = 3;
        load_phase(4'b1010, 1, 1, 4, 4);
        wait_drain();
        force_gap_port = -1;

        // Reset on beat 2 of a 6-beat packet from port 1.
        do_reset();
        sb_en = 1'b0;
        for (int j = 0; j < 6; j++) port_q[1].push_back({(j == 5), 4'hF, DW'(32'hA000 + j)});
        n = 0;
        while (port_q[1].size() != 5 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("rst_mid_reach_beat2", port_q[1].size(), 5);
        aresetn = 1'b0;
        for (int p = 0; p < NP; p++) port_q[p].delete();
        exp_q.delete();
        model_lg = NP - 1;
        @(posedge clk); #2;
        aresetn = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        sb_en = 1'b1;
        @(posedge clk); #2;
        load_phase(4'b0011, 1, 1, 2, 4);
        wait_drain();

        // Single-port build: back-to-back 1-beat packets.
        @(posedge clk); #2;
        bus1.s_axis_tvalid = 1'b1; bus1.s_axis_tlast = 1'b1; bus1.s_axis_tkeep = 4'hF;
        bus1.s_axis_tdata = 32'h100;
        nacc = 0; since = -1; prev_acc1 = 1'b0; prev_data = '0;
        repeat (24) begin
            @(negedge clk);
            acc1 = bus1.s_axis_tvalid[0] & bus1.s_axis_tready[0];
            if (prev_acc1)
                check("np1_out", {bus1.m_axis_tvalid, bus1.m_axis_tid, bus1.m_axis_tlast, bus1.m_axis_tdata},
                      {1'b1, 1'b0, 1'b1, prev_data});
            if (since >= 0) since++;
            if (acc1) begin
                if (since >= 0) check("np1_gap", since, 2);
                since = 0;
                nacc++;
            end
            prev_acc1 = acc1;
            prev_data = bus1.s_axis_tdata;
            @(posedge clk); #1;
            if (acc1) bus1.s_axis_tdata = bus1.s_axis_tdata + 1;
        end
        check("np1_accept_count", (nacc >= 11 && nacc <= 12), 1);
        bus1.s_axis_tvalid = '0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
